uart_digit_receiver: RTL and testbench
======================================

# uart_digit_receiver

UART receive counterpart to the digit transmit path. Accepts 8N1 serial frames on `Rxd` and decodes ASCII characters '0'–'9' (0x30–0x39) into 4-bit digit values. It assembles each group of four consecutive digits and presents them as `LED0`..`LED3` for the seven-segment display path. Sits between the board's UART RX pin and the seven-segment block's digit inputs.

## Interface
- `CLKS_PER_BIT`, default 10416, clock cycles per UART bit (100 MHz / 9600 baud); must be ≥ 4.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `Rxd`  in  1  asynchronous serial input; idles high.
- `LED0`  out  4  digit from the 1st character of the last complete group.
- `LED1`  out  4  digit from the 2nd character.
- `LED2`  out  4  digit from the 3rd character.
- `LED3`  out  4  digit from the 4th character.
- `digits_valid`  out  1  one-cycle pulse; `LED0`..`LED3` were just updated.
- `frame_error`  out  1  one-cycle pulse; stop bit was sampled low.
- `char_error`  out  1  one-cycle pulse; a well-framed byte was not an ASCII digit.

## Operation
- **Synchronizer.** `Rxd` passes through a 2-flop synchronizer; all FSM logic uses the synchronized value `rx_s`.
- **Bit counter.** One bit-timer counts 0..`CLKS_PER_BIT`-1. One 3-bit index selects the data bit. Data is received LSB first into an 8-bit shift register.
- **FSM states:**
  - IDLE: stay while `rx_s`=1. On `rx_s`=0, go to START and clear the timer.
  - START: at timer = `CLKS_PER_BIT`/2 − 1 (mid-bit), sample `rx_s`. If 0, go to DATA and clear the timer and bit index. If 1, treat as a glitch and return to IDLE with no outputs.
  - DATA: at timer = `CLKS_PER_BIT`−1, sample `rx_s` into bit[index] and clear the timer. After bit 7 is sampled, go to STOP.
  - STOP: at timer = `CLKS_PER_BIT`−1, sample `rx_s`. If 1, the byte is accepted and the FSM goes to IDLE. If 0, pulse `frame_error`, discard the byte, and go to BREAK.
  - BREAK: wait until `rx_s`=1, then go to IDLE. A held-low line must never be taken as a new start bit.
- **Digit assembly.** A 2-bit slot index `idx` and four 4-bit shadow registers are kept. On each accepted byte:
  - Byte in 0x30–0x39: shadow[`idx`] ← byte − 0x30.
    - If `idx`=3, copy all four shadows to `LED0`..`LED3` in the same cycle, pulse `digits_valid`, and set `idx`←0. The 4th digit goes directly to `LED3`.
    - Otherwise `idx`←`idx`+1.
  - Any other byte: pulse `char_error`, set `idx`←0, and discard the partial group.
- `LED0`..`LED3` change only when `digits_valid` pulses. They hold their values otherwise, including across all error conditions.
- A `frame_error` also resets `idx` to 0.
- At most one of `digits_valid`, `frame_error`, `char_error` is high in any cycle.

## Timing
- **Reset** (`rst`=1 at a rising edge):
  - FSM → IDLE; timer, bit index and `idx` cleared; shadows cleared.
  - `LED0`..`LED3` = 0; `digits_valid` = `frame_error` = `char_error` = 0.
  - Reset mid-frame aborts the frame; reception resumes at the next falling edge seen in IDLE.
  - The synchronizer flops reset to 1.
- **Input latency:** a falling edge on `Rxd` reaches `rx_s` 2 cycles later.
- **Sample points:** the start bit is sampled `CLKS_PER_BIT`/2 cycles after IDLE sees `rx_s`=0. Each later sample follows the previous one by exactly `CLKS_PER_BIT` cycles.
- **Output pulses:** `digits_valid`, `frame_error`, `char_error` and the `LED` update are registered. They become visible the cycle after the stop-bit sample edge and last exactly 1 cycle.
- **Back-to-back frames:** supported. IDLE is re-entered right after the stop sample, so a start bit that begins immediately after the stop bit is detected.
- **Accuracy:** baud-rate mismatch up to ±2% must still decode correctly.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Reset → hold `rst` 3 cycles with `Rxd`=1: all outputs 0, no pulses for 500 cycles afterwards.
- Send "1234" back-to-back → exactly one `digits_valid` pulse, 1 cycle after the 4th stop sample. Then `LED0`=1, `LED1`=2, `LED2`=3, `LED3`=4. LEDs stay 0 before that pulse.
- Send "12A3456" after the previous test → `char_error` pulses at 'A' and LEDs hold 1,2,3,4. After '6', `digits_valid` pulses and LEDs = 3,4,5,6.
- Send '7' with the stop bit driven low, then hold `Rxd` low 48 cycles, release high, then send "9876":
  - `frame_error` pulses once; no start is detected while the line is low.
  - LEDs end at 9,8,7,6.
- Drive a 5-cycle low glitch on idle `Rxd` → no pulses and no LED change; a following "0000" gives LEDs 0,0,0,0.
- Send "55", assert `rst` 1 cycle midway through the next frame, then send "4321" → outputs 0 after reset. LEDs = 4,3,2,1 with a single `digits_valid`.

Source files
------------

// File: rtl/uart_digit_receiver.sv
// 8N1 UART receiver that decodes ASCII '0'..'9' and publishes each group of
// four digits to LED0..LED3 with a one-cycle digits_valid strobe.
module uart_digit_receiver #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       Rxd,
    output logic [3:0] LED0,
    output logic [3:0] LED1,
    output logic [3:0] LED2,
    output logic [3:0] LED3,
    output logic       digits_valid,
    output logic       frame_error,
    output logic       char_error
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [2:0]    r_state;
    logic [TW-1:0] r_timer;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [1:0]    r_idx;
    logic [3:0]    r_shadow [4];
    logic [3:0]    r_led    [4];
    logic          r_dv;
    logic          r_fe;
    logic          r_ce;

    logic          w_is_digit;
    logic [3:0]    w_digit;

    // 0x30..0x39 share the upper nibble 3, so the digit value is the low nibble.
    assign w_is_digit = (r_shift >= 8'h30) && (r_shift <= 8'h39);
    assign w_digit    = r_shift[3:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= ST_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_idx     <= '0;
            r_dv      <= 1'b0;
            r_fe      <= 1'b0;
            r_ce      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_shadow[i] <= '0;
                r_led[i]    <= '0;
            end
        end else begin
            r_rx_meta <= Rxd;
            r_rx_s    <= r_rx_meta;
            r_dv      <= 1'b0;
            r_fe      <= 1'b0;
            r_ce      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_timer <= '0;
                    end
                end
                ST_START: begin
                    if (r_timer == HALF_LAST) begin
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer            <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        r_bit_idx          <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_timer == BIT_LAST) begin
                        r_timer <= '0;
                        if (r_rx_s) begin
                            r_state <= ST_IDLE;
                            if (w_is_digit) begin
                                r_shadow[r_idx] <= w_digit;
                                if (r_idx == 2'd3) begin
                                    // The 4th digit bypasses its shadow so the group lands in one cycle.
                                    r_led[0] <= r_shadow[0];
                                    r_led[1] <= r_shadow[1];
                                    r_led[2] <= r_shadow[2];
                                    r_led[3] <= w_digit;
                                    r_dv     <= 1'b1;
                                    r_idx    <= 2'd0;
                                end else begin
                                    r_idx <= r_idx + 1'b1;
                                end
                            end else begin
                                r_ce  <= 1'b1;
                                r_idx <= 2'd0;
                            end
                        end else begin
                            r_fe    <= 1'b1;
                            r_idx   <= 2'd0;
                            r_state <= ST_BREAK;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must rise before another start bit is accepted.
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign LED0         = r_led[0];
    assign LED1         = r_led[1];
    assign LED2         = r_led[2];
    assign LED3         = r_led[3];
    assign digits_valid = r_dv;
    assign frame_error  = r_fe;
    assign char_error   = r_ce;

endmodule

// File: tb/tb_uart_digit_receiver.sv
// Randomized bench for uart_digit_receiver: serial frames are checked against a
// queue-based model of digit grouping, pulse counts, pulse latency and LED stability.
module tb_uart_digit_receiver;

    localparam int CPB     = 16;
    localparam int LAT     = 155;  // Rxd fall to visible pulse: 2 sync + 1 + CPB/2 + 9*CPB
    localparam int EV_NONE = 0;
    localparam int EV_DV   = 1;
    localparam int EV_FE   = 2;
    localparam int EV_CE   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Rxd = 1'b1;
    logic [3:0] LED0, LED1, LED2, LED3;
    logic       digits_valid, frame_error, char_error;

    uart_digit_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .Rxd(Rxd),
        .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3),
        .digits_valid(digits_valid), .frame_error(frame_error), .char_error(char_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_dv = 0, n_fe = 0, n_ce = 0, n_multi = 0, n_led_bad = 0;
    int last_pulse = 0;
    int frame_start = 0;
    logic        rst_d = 1'b0;
    logic [15:0] prev_leds = '0;
    logic [15:0] leds;

    assign leds = {LED3, LED2, LED1, LED0};

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse/LED monitor, sampled on the falling edge; the cycle around a reset is ignored.
    always @(negedge clk) begin
        if (!(rst || rst_d)) begin
            if (digits_valid) begin n_dv <= n_dv + 1; last_pulse <= cyc; end
            if (frame_error)  begin n_fe <= n_fe + 1; last_pulse <= cyc; end
            if (char_error)   begin n_ce <= n_ce + 1; last_pulse <= cyc; end
            if (int'(digits_valid) + int'(frame_error) + int'(char_error) > 1)
                n_multi <= n_multi + 1;
            if (leds != prev_leds && !digits_valid)
                n_led_bad <= n_led_bad + 1;
        end
        prev_leds <= leds;
        rst_d     <= rst;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: pending digits in a queue, published when four accumulate.
    int          m_q[$];
    logic [15:0] m_leds = '0;

    task automatic model_reset();
        m_q.delete();
        m_leds = '0;
    endtask

    task automatic model_apply(input logic [7:0] b, input bit ok, output int ev);
        int v;
        v = int'(b);
        if (!ok) begin
            m_q.delete();
            ev = EV_FE;
        end else if (v >= 48 && v <= 57) begin
            m_q.push_back(v - 48);
            ev = EV_NONE;
            if (m_q.size() == 4) begin
                m_leds = 16'(m_q[0] + 16 * m_q[1] + 256 * m_q[2] + 4096 * m_q[3]);
                m_q.delete();
                ev = EV_DV;
            end
        end else begin
            m_q.delete();
            ev = EV_CE;
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    // Drives one frame with bit period CPB*f; a bad frame keeps the line low for hold extra cycles.
    task automatic send_frame(input logic [7:0] b, input bit ok, input real f, input int hold);
        int target;
        step();
        frame_start = cyc;
        for (int n = 0; n < 10; n++) begin
            if (n == 0)      Rxd = 1'b0;
            else if (n <= 8) Rxd = b[n-1];
            else             Rxd = ok;
            target = $rtoi(real'(CPB) * f * real'(n + 1) + 0.5);
            while (cyc - frame_start < target) step();
        end
        if (!ok) repeat (hold) step();
        Rxd = 1'b1;
    endtask

    task automatic do_frame(input logic [7:0] b, input bit ok, input real f, input int hold, input int gap);
        int dv0, fe0, ce0, ev;
        dv0 = n_dv; fe0 = n_fe; ce0 = n_ce;
        model_apply(b, ok, ev);
        send_frame(b, ok, f, hold);
        repeat (gap) step();
        check_val($sformatf("DV_%02h", b), 32'(n_dv - dv0), 32'(ev == EV_DV));
        check_val($sformatf("FE_%02h", b), 32'(n_fe - fe0), 32'(ev == EV_FE));
        check_val($sformatf("CE_%02h", b), 32'(n_ce - ce0), 32'(ev == EV_CE));
        check_val($sformatf("LEDS_%02h", b), 32'(leds), 32'(m_leds));
        if (ev != EV_NONE)
            check_val($sformatf("LAT_%02h", b), 32'(last_pulse - frame_start), 32'(LAT));
        $display("frame %02h ok=%0d f=%0.3f ev=%0d leds=%04h", b, ok, f, ev, leds);
    endtask

    task automatic send_str(input string s, input int gap);
        for (int i = 0; i < s.len(); i++) do_frame(s[i], 1'b1, 1.0, 0, gap);
    endtask

    int dv0, fe0, ce0;

    initial begin
        // Reset and quiet line
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        model_reset();
        check_val("RST_LEDS", 32'(leds), 32'(0));
        check_val("RST_DV", 32'(digits_valid), 32'(0));
        check_val("RST_FE", 32'(frame_error), 32'(0));
        check_val("RST_CE", 32'(char_error), 32'(0));
        repeat (500) step();
        check_val("QUIET_PULSES", 32'(n_dv + n_fe + n_ce), 32'(0));

        send_str("1234", 0);
        send_str("12A3456", 0);

        // Framing error followed by a long break
        do_frame("7", 1'b0, 1.0, 48, 6);
        send_str("9876", 0);

        // Short low glitch on an idle line
        dv0 = n_dv; fe0 = n_fe; ce0 = n_ce;
        Rxd = 1'b0;
        repeat (5) step();
        Rxd = 1'b1;
        repeat (40) step();
        check_val("GLITCH_PULSES", 32'(n_dv + n_fe + n_ce - dv0 - fe0 - ce0), 32'(0));
        check_val("GLITCH_LEDS", 32'(leds), 32'(m_leds));
        send_str("0000", 1);

        // Reset in the middle of a frame whose remaining bits are all high
        send_str("55", 0);
        dv0 = n_dv; fe0 = n_fe; ce0 = n_ce;
        fork
            send_frame(8'hF0, 1'b1, 1.0, 0);
            begin
                step();
                repeat (6 * CPB + CPB / 2) step();
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
        join
        model_reset();
        repeat (20) step();
        check_val("MIDRST_LEDS", 32'(leds), 32'(0));
        check_val("MIDRST_PULSES", 32'(n_dv + n_fe + n_ce - dv0 - fe0 - ce0), 32'(0));
        send_str("4321", 0);

        // Randomized traffic with up to +/-2% baud mismatch
        for (int i = 0; i < 60; i++) begin
            int   r;
            real  f;
            logic [7:0] b;
            r = $urandom_range(0, 99);
            f = 0.98 + real'($urandom_range(0, 40)) / 1000.0;
            if (r < 70) begin
                b = 8'(8'h30 + $urandom_range(0, 9));
                do_frame(b, 1'b1, f, 0, $urandom_range(0, 4));
            end else if (r < 85) begin
                b = 8'($urandom);
                do_frame(b, 1'b1, f, 0, $urandom_range(0, 4));
            end else begin
                b = 8'($urandom);
                do_frame(b, 1'b0, f, $urandom_range(0, 48), $urandom_range(2, 6));
            end
        end

        repeat (20) step();
        check_val("MULTI_PULSE", 32'(n_multi), 32'(0));
        check_val("LED_UNSTROBED", 32'(n_led_bad), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
